// File: rtl/ports_pwm_pkg.sv
// Shared definitions for the Avalon-MM LED/GPIO PWM output peripheral.
// Register word offsets and the per-pin output mode encoding.
package ports_pwm_pkg;

  localparam int REG_CTRL     = 0;
  localparam int REG_PRESCALE = 1;
  localparam int REG_OUT      = 2;
  localparam int REG_MODE     = 3;
  localparam int REG_DUTY0    = 4;

  typedef enum logic [1:0] {
    MODE_STATIC  = 2'b00,
    MODE_PWM     = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_PWM_INV = 2'b11
  } pin_mode_e;

endpackage

// File: rtl/avalon_ports_pwm_pin.sv
// Combinational level of one output pin from its mode, duty and the
// shared PWM / blink time base.
module pwm_pin
  import ports_pwm_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  pin_mode_e             i_mode,
  input  logic [PWM_BITS:0]     i_duty,
  input  logic                  i_out,
  input  logic [PWM_BITS-1:0]   i_wcnt,
  input  logic                  i_blink,
  output logic                  o_level
);

  logic w_pwm;

  // One extra bit lets a duty of 2^PWM_BITS hold the pin high.
  assign w_pwm = {1'b0, i_wcnt} < i_duty;

  always_comb begin
    o_level = 1'b0;
    unique case (i_mode)
      MODE_STATIC:  o_level = i_out;
      MODE_PWM:     o_level = w_pwm;
      MODE_BLINK:   o_level = i_out & i_blink;
      MODE_PWM_INV: o_level = ~w_pwm;
    endcase
  end

endmodule

// File: rtl/avalon_ports_pwm.sv
// Avalon-MM output peripheral: register file, shared prescaled PWM and
// blink time base, and registered per-pin outputs.
module avalon_ports_pwm
  import ports_pwm_pkg::*;
#(
  parameter int NUM_PINS      = 8,
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE_BITS = 16,
  parameter int ADDR_W        = $clog2(4 + NUM_PINS)
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [ADDR_W-1:0]   avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  output logic [31:0]         avs_readdata,
  output logic [NUM_PINS-1:0] ports_out
);

  logic                     r_en;
  logic [PRESCALE_BITS-1:0] r_prescale;
  logic [NUM_PINS-1:0]      r_out;
  logic [2*NUM_PINS-1:0]    r_mode;
  logic [PWM_BITS:0]        r_duty [NUM_PINS];

  logic [PRESCALE_BITS-1:0] r_pcnt;
  logic [PWM_BITS-1:0]      r_wcnt;
  logic [PWM_BITS-1:0]      r_bcnt;

  logic                     w_wr_ctrl;
  logic                     w_wr_ps;
  logic                     w_restart;
  logic                     w_tick;
  logic [NUM_PINS-1:0]      w_level;
  logic [31:0]              w_rdata;
  logic                     w_unused;

  assign w_wr_ctrl = avs_write && (avs_address == ADDR_W'(REG_CTRL));
  assign w_wr_ps   = avs_write && (avs_address == ADDR_W'(REG_PRESCALE));
  assign w_restart = w_wr_ps || (w_wr_ctrl && avs_writedata[0] && !r_en);
  assign w_tick    = (r_pcnt == r_prescale);
  assign w_unused  = &{1'b0, avs_writedata};

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_en       <= 1'b0;
      r_prescale <= '0;
      r_out      <= '0;
      r_mode     <= '0;
      for (int i = 0; i < NUM_PINS; i++) r_duty[i] <= '0;
    end else if (avs_write) begin
      if (avs_address == ADDR_W'(REG_CTRL))
        r_en <= avs_writedata[0];
      if (avs_address == ADDR_W'(REG_PRESCALE))
        r_prescale <= avs_writedata[PRESCALE_BITS-1:0];
      if (avs_address == ADDR_W'(REG_OUT))
        r_out <= avs_writedata[NUM_PINS-1:0];
      if (avs_address == ADDR_W'(REG_MODE))
        r_mode <= avs_writedata[2*NUM_PINS-1:0];
      for (int i = 0; i < NUM_PINS; i++)
        if (avs_address == ADDR_W'(REG_DUTY0 + i))
          r_duty[i] <= avs_writedata[PWM_BITS:0];
    end
  end

  // Counters sit at zero while disabled and restart phase-aligned.
  always_ff @(posedge clk_clk) begin
    if (reset_reset || w_restart || !r_en) begin
      r_pcnt <= '0;
      r_wcnt <= '0;
      r_bcnt <= '0;
    end else if (w_tick) begin
      r_pcnt <= '0;
      r_wcnt <= r_wcnt + 1'b1;
      if (&r_wcnt) r_bcnt <= r_bcnt + 1'b1;
    end else begin
      r_pcnt <= r_pcnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_PINS; g++) begin : g_pin
    pwm_pin #(.PWM_BITS(PWM_BITS)) u_pin (
      .i_mode  (pin_mode_e'(r_mode[2*g +: 2])),
      .i_duty  (r_duty[g]),
      .i_out   (r_out[g]),
      .i_wcnt  (r_wcnt),
      .i_blink (r_bcnt[PWM_BITS-1]),
      .o_level (w_level[g])
    );
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset || !r_en) ports_out <= '0;
    else                      ports_out <= w_level;
  end

  always_comb begin
    w_rdata = '0;
    if (avs_address == ADDR_W'(REG_CTRL))
      w_rdata[0] = r_en;
    if (avs_address == ADDR_W'(REG_PRESCALE))
      w_rdata[PRESCALE_BITS-1:0] = r_prescale;
    if (avs_address == ADDR_W'(REG_OUT))
      w_rdata[NUM_PINS-1:0] = r_out;
    if (avs_address == ADDR_W'(REG_MODE))
      w_rdata[2*NUM_PINS-1:0] = r_mode;
    for (int i = 0; i < NUM_PINS; i++)
      if (avs_address == ADDR_W'(REG_DUTY0 + i))
        w_rdata[PWM_BITS:0] = r_duty[i];
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset)   avs_readdata <= '0;
    else if (avs_read) avs_readdata <= w_rdata;
  end

endmodule
